// File: rtl/slow_tick_monitor.sv
// Qualifies rising edges of an asynchronous divided clock into single-cycle ticks and measures the tick period.
// Latency: a tick appears on the third clk edge after slow_clk_in is first sampled high. Every output comes straight from a flop.
// Backpressure: none. The block only observes; a missing edge leads to a sticky FAULT that only clear releases.
module slow_tick_monitor #(
  parameter int TIMEOUT = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slow_clk_in,
  input  logic             enable,
  input  logic             clear,
  output logic             tick,
  output logic [CNT_W-1:0] tick_count,
  output logic [7:0]       period,
  output logic             period_valid,
  output logic             timeout_err,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    FAULT = 2'd3
  } state_t;

  localparam logic [7:0] GAP_LIMIT = 8'(TIMEOUT - 1);

  state_t     state;
  state_t     state_nxt;
  logic       s1;
  logic       s2;
  logic       s3;
  logic [1:0] primed;
  logic       rise;
  logic [7:0] gap;
  logic       active;
  logic       timeout_hit;
  logic       tick_nxt;
  logic       pv_nxt;
  logic       arm_entry;

  // Two-flop synchronizer with a history flop. For the first two edges after
  // reset, s3 loads from the same source as s2. An input held high across the
  // release of reset therefore fills s2 and s3 together and does not look like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      s3     <= 1'b0;
      primed <= 2'b00;
    end else begin
      s1     <= slow_clk_in;
      s2     <= s1;
      s3     <= primed[1] ? s2 : s1;
      primed <= {primed[0], 1'b1};
    end
  end

  assign rise   = s2 & ~s3;
  assign active = (state == ARMED) || (state == RUN);

  // Timeout fires only when no rise is present. A rise in the limit cycle wins.
  // A clear in that cycle also resets the gap, so it suppresses the fault.
  assign timeout_hit = active && enable && !rise && !clear && (gap == GAP_LIMIT);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic: dropping enable takes priority over a rise
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable) state_nxt = ARMED;
      ARMED,
      RUN: begin
        if (!enable)          state_nxt = IDLE;
        else if (rise)        state_nxt = RUN;
        else if (timeout_hit) state_nxt = FAULT;
      end
      FAULT: if (clear) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode: next values for the registered tick and period strobes
  always_comb begin
    tick_nxt  = 1'b0;
    pv_nxt    = 1'b0;
    arm_entry = 1'b0;
    if (active && enable && rise) tick_nxt = 1'b1;
    if ((state == RUN) && enable && rise) pv_nxt = 1'b1;
    if ((state == IDLE) && enable) arm_entry = 1'b1;
  end

  // Gap counter: restarts on each rise and on arming, and saturates at 255
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          gap <= 8'd0;
    else if (clear || arm_entry)         gap <= 8'd0;
    else if (active && rise)             gap <= 8'd0;
    else if (active && (gap != 8'hFF))   gap <= gap + 8'd1;
  end

  // Registered outputs. A clear overrides the counter, period and fault updates, but the tick pulse still goes out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick         <= 1'b0;
      period_valid <= 1'b0;
      tick_count   <= '0;
      period       <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      tick         <= tick_nxt;
      period_valid <= pv_nxt;
      if (clear) begin
        tick_count  <= '0;
        period      <= 8'd0;
        timeout_err <= 1'b0;
      end else begin
        if (tick_nxt)    tick_count  <= tick_count + CNT_W'(1);
        if (pv_nxt)      period      <= gap + 8'd1;
        if (timeout_hit) timeout_err <= 1'b1;
      end
    end
  end

  assign state_o = state;

endmodule

// File: doc/slow_tick_monitor.md
SLOW_TICK_MONITOR -- requirements
Module: slow_tick_monitor

Interface
REQ-001 Parameter: TIMEOUT, 8, max clk cycles allowed between synchronized rising edges; legal range 2..255.
REQ-002 Parameter: CNT_W, 16, width of tick_count.
REQ-003 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-005 Port: slow_clk_in  input  1  divided clock from the clock divider, treated as asynchronous data.
REQ-006 Port: enable  input  1  synchronous run request.
REQ-007 Port: clear  input  1  synchronous clear of counters and fault.
REQ-008 Port: tick  output  1  one-cycle pulse per qualified rising edge of slow_clk_in.
REQ-009 Port: tick_count  output  CNT_W  number of ticks since reset or clear.
REQ-010 Port: period  output  8  clk cycles between the last two qualified rising edges.
REQ-011 Port: period_valid  output  1  one-cycle pulse when period updates.
REQ-012 Port: timeout_err  output  1  sticky fault flag.
REQ-013 Port: state_o  output  2  FSM state: IDLE=0, ARMED=1, RUN=2, FAULT=3.

Function
REQ-014 slow_clk_in SHALL pass through a two-flop synchronizer (s1, s2) plus a history flop (s3); rise = s2 AND NOT s3.
REQ-015 tick SHALL be registered, and SHALL assert on the third clk edge counting from the first edge that samples slow_clk_in high, provided the FSM is in ARMED or RUN when rise is evaluated.
REQ-016 A gap counter (8 bits, saturating at 255) SHALL reset to 0 on rise and on entry to ARMED, and SHALL otherwise increment each cycle in ARMED or RUN.
REQ-017 IDLE: enable=1 -> ARMED; otherwise remain in IDLE; no ticks are produced.
REQ-018 ARMED: rise -> RUN with tick=1, period unchanged, and period_valid=0.
REQ-019 RUN: rise -> period <= gap+1, with period_valid=1 and tick=1 in the same cycle.
REQ-020 ARMED/RUN timeout: if gap == TIMEOUT-1 and rise=0 -> FAULT, with timeout_err <= 1; if rise coincides with that cycle, rise wins and no fault is raised.
REQ-021 ARMED/RUN: enable=0 -> IDLE at the next edge, overriding rise; no tick is produced; tick_count and period are retained.
REQ-022 FAULT: the FSM stays in FAULT regardless of enable or rise; no ticks are produced; only clear exits (to IDLE).
REQ-023 tick_count SHALL increment by 1 each tick and wrap from 2^CNT_W-1 to 0 without a flag.
REQ-024 clear=1 SHALL set tick_count, period, timeout_err, and gap to 0; FAULT -> IDLE; other states are unchanged.
REQ-025 clear coincident with a tick: clear wins, so tick_count=0; the tick pulse itself is still emitted.
REQ-026 All outputs SHALL be driven directly from flops; there is no combinational path from input to output.

Reset
REQ-027 rst_n=0 SHALL immediately force: state IDLE, s1/s2/s3=0, gap=0, tick=0, tick_count=0, period=0, period_valid=0, timeout_err=0.
REQ-028 Reset asserted mid-operation SHALL abort any pending tick; after release, operation resumes from IDLE and requires enable=1.
REQ-029 slow_clk_in held high across reset release SHALL NOT produce a rise, because s3 settles high together with s2.

Verification
REQ-030 enable=1; slow_clk_in high one cycle in every 3 for 5 pulses -> 5 ticks, tick_count=5, period=3, 4 period_valid pulses.
REQ-031 TIMEOUT=8, RUN, slow_clk_in held low -> state_o=3 and timeout_err=1 exactly 8 edges after the last rise; ticks then ignored.
REQ-032 In FAULT, clear=1 for one cycle -> state_o=0, timeout_err=0, tick_count=0, period=0.
REQ-033 CNT_W=4, 17 ticks -> tick_count=1 (wrapped).
REQ-034 Deassert enable in the same cycle that rise is high -> no tick, state_o=0, tick_count unchanged.
REQ-035 Pulse rst_n low asynchronously mid-RUN -> all outputs 0 before the next clk edge; the first tick after re-enable leaves period_valid=0.
